// File: rtl/bus_monitor_if.sv
// Core bus tap and log-consumer handshake shared by the monitor and its environment.
interface bus_monitor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_wr;
  logic [DATA_W-1:0] data_rd;
  logic              we;
  logic              log_valid;
  logic              log_ready;
  logic [ADDR_W-1:0] log_addr;
  logic [DATA_W-1:0] log_data;
  logic              log_is_write;

  modport master (
    output address, data_wr, data_rd, we, log_ready,
    input  log_valid, log_addr, log_data, log_is_write
  );

  modport slave (
    input  address, data_wr, data_rd, we, log_ready,
    output log_valid, log_addr, log_data, log_is_write
  );
endinterface

// File: rtl/bus_monitor.sv
// Watches a core bus, logs MMIO-window accesses into a FIFO and stops the run on a
// halt-address access or after a cycle limit.
module bus_monitor #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'('hFFC),
  parameter int unsigned       MMIO_BIT   = 11,
  parameter bit                LOG_READS  = 1'b0,
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter int unsigned       TIMEOUT    = 4000
) (
  input  logic         clk,
  input  logic         reset,
  bus_monitor_if.slave bus,
  output logic         halted,
  output logic         timed_out,
  output logic         done,
  output logic         overflow,
  output logic [31:0]  drop_count,
  output logic [31:0]  cycle_count
);
  localparam int unsigned CNT_W = 32;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              is_write;
  } entry_t;

  typedef enum logic {RUN = 1'b0, STOPPED = 1'b1} state_t;

  state_t           state;
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] count;
  logic             head_valid;

  logic             push_c;
  logic             pop_c;
  logic             full_c;
  logic             wr_en_c;
  logic             drop_c;
  logic             halt_hit_c;
  logic             tmo_hit_c;
  logic [OCC_W-1:0] count_nxt_c;

  // Event qualification and FIFO occupancy bookkeeping
  always_comb begin
    push_c      = (state == RUN) && bus.address[MMIO_BIT] && (bus.we || LOG_READS);
    pop_c       = head_valid && bus.log_ready;
    full_c      = (count == OCC_W'(FIFO_DEPTH));
    wr_en_c     = push_c && (!full_c || pop_c);
    drop_c      = push_c && full_c && !pop_c;
    halt_hit_c  = (bus.address == HALT_ADDR);
    tmo_hit_c   = (cycle_count == CNT_W'(TIMEOUT - 1));
    count_nxt_c = count;
    if (wr_en_c && !pop_c) begin
      count_nxt_c = count + OCC_W'(1);
    end else if (pop_c && !wr_en_c) begin
      count_nxt_c = count - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)   rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_nxt_c;
      head_valid <= (count_nxt_c != '0);
    end
  end

  // Storage needs no reset: pointers alone define what is live
  always_ff @(posedge clk) begin
    if (!reset && wr_en_c) begin
      mem[wr_ptr] <= '{addr:     bus.address,
                       data:     bus.we ? bus.data_wr : bus.data_rd,
                       is_write: bus.we};
    end
  end

  assign bus.log_valid    = head_valid;
  assign bus.log_addr     = mem[rd_ptr].addr;
  assign bus.log_data     = mem[rd_ptr].data;
  assign bus.log_is_write = mem[rd_ptr].is_write;

  // Run/stop control; halt wins over a simultaneous timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      halted      <= 1'b0;
      timed_out   <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
      cycle_count <= '0;
    end else begin
      if (drop_c) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (!tmo_hit_c) cycle_count <= cycle_count + CNT_W'(1);
          if (halt_hit_c) begin
            halted <= 1'b1;
            done   <= 1'b1;
            state  <= STOPPED;
          end else if (tmo_hit_c) begin
            timed_out <= 1'b1;
            done      <= 1'b1;
            state     <= STOPPED;
          end
        end
        STOPPED: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_monitor.sv
// Directed and randomized checks of bus_monitor: one default-parameter instance with a
// queue-based reference model, and one with LOG_READS=1 and TIMEOUT=16.
module tb_bus_monitor;
  localparam int unsigned TIMEOUT_A = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        halted_a, timed_out_a, done_a, overflow_a;
  logic        halted_b, timed_out_b, done_b, overflow_b;
  logic [31:0] drop_a, cyc_a, drop_b, cyc_b;

  bus_monitor_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
  bus_monitor_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

  bus_monitor #(.TIMEOUT(TIMEOUT_A)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa),
    .halted(halted_a), .timed_out(timed_out_a), .done(done_a),
    .overflow(overflow_a), .drop_count(drop_a), .cycle_count(cyc_a)
  );

  bus_monitor #(.LOG_READS(1'b1), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb),
    .halted(halted_b), .timed_out(timed_out_b), .done(done_b),
    .overflow(overflow_b), .drop_count(drop_b), .cycle_count(cyc_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model for dut_a: a queue of logged entries plus run flags
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        w;
  } ent_t;
  ent_t        mq[$];
  logic        m_halted, m_tmo, m_ovf;
  logic [31:0] m_drops, m_cycles;

  task automatic model_a(input logic r, input logic [31:0] a, wd, input logic w, rdy);
    logic stopped, pop, full;
    ent_t e;
    if (r) begin
      mq.delete();
      m_halted = 0; m_tmo = 0; m_ovf = 0; m_drops = 0; m_cycles = 0;
      return;
    end
    stopped = m_halted || m_tmo;
    pop     = (mq.size() != 0) && rdy;
    full    = (mq.size() == 8);
    if (pop) e = mq.pop_front();
    if (!stopped && a[11] && w) begin
      if (full && !pop) begin
        m_ovf = 1;
        if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
      end else begin
        e.addr = a; e.data = wd; e.w = 1'b1;
        mq.push_back(e);
      end
    end
    if (!stopped) begin
      if (a == 32'hFFC) m_halted = 1;
      else if (m_cycles == TIMEOUT_A - 1) m_tmo = 1;
      if (m_cycles != TIMEOUT_A - 1) m_cycles = m_cycles + 1;
    end
  endtask

  task automatic tick_a(input logic r, input logic [31:0] a, wd, rd, input logic w, rdy);
    rst_a = r; ifa.address = a; ifa.data_wr = wd; ifa.data_rd = rd;
    ifa.we = w; ifa.log_ready = rdy;
    model_a(r, a, wd, w, rdy);
    @(posedge clk); #1;
  endtask

  task automatic tick_b(input logic r, input logic [31:0] a, wd, rd, input logic w, rdy);
    rst_b = r; ifb.address = a; ifb.data_wr = wd; ifb.data_rd = rd;
    ifb.we = w; ifb.log_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    tick_a(1, 0, 0, 0, 0, 0);
    tick_a(1, 32'h800, 32'h1, 32'h2, 1, 1);
    tests++;
    if ({ifa.log_valid, halted_a, timed_out_a, done_a, overflow_a, drop_a, cyc_a} !== 69'd0) begin
      fails++;
      $display("FAIL reset_a: got v=%b h=%b t=%b d=%b o=%b drop=%0d cyc=%0d, want all zero",
               ifa.log_valid, halted_a, timed_out_a, done_a, overflow_a, drop_a, cyc_a);
    end
    tests++;
    if ({ifb.log_valid, halted_b, timed_out_b, done_b, overflow_b, drop_b, cyc_b} !== 69'd0) begin
      fails++;
      $display("FAIL reset_b: got v=%b h=%b t=%b d=%b o=%b drop=%0d cyc=%0d, want all zero",
               ifb.log_valid, halted_b, timed_out_b, done_b, overflow_b, drop_b, cyc_b);
    end
  endtask

  task automatic test_single_write();
    tick_a(0, 32'h800, 32'hDEADBEEF, 32'h0, 1, 1);
    tests++;
    if ({ifa.log_valid, ifa.log_addr, ifa.log_data, ifa.log_is_write, cyc_a} !==
        {1'b1, 32'h800, 32'hDEADBEEF, 1'b1, 32'd1}) begin
      fails++;
      $display("FAIL single_write: got v=%b a=%h d=%h w=%b cyc=%0d, want 1 800 deadbeef 1 1",
               ifa.log_valid, ifa.log_addr, ifa.log_data, ifa.log_is_write, cyc_a);
    end
    tick_a(0, 32'h0, 32'h0, 32'h0, 0, 1);
    tests++;
    if (ifa.log_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_pop: got log_valid=%b, want 0", ifa.log_valid);
    end
  endtask

  task automatic test_overflow();
    tick_a(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick_a(0, 32'h800 + 32'(4 * i), 32'(100 + i), 32'h0, 1, 0);
      if (i == 7) begin
        tests++;
        if ({overflow_a, drop_a} !== {1'b0, 32'd0}) begin
          fails++;
          $display("FAIL full_no_drop: got ovf=%b drop=%0d, want 0 0", overflow_a, drop_a);
        end
      end
    end
    tests++;
    if ({ifa.log_valid, ifa.log_addr, ifa.log_data, overflow_a, drop_a} !==
        {1'b1, 32'h800, 32'd100, 1'b1, 32'd2}) begin
      fails++;
      $display("FAIL overflow: got v=%b a=%h d=%0d ovf=%b drop=%0d, want 1 800 100 1 2",
               ifa.log_valid, ifa.log_addr, ifa.log_data, overflow_a, drop_a);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] ea, ed;
    tick_a(0, 32'h900, 32'hAAAA_0000, 32'h0, 1, 1);
    tests++;
    if ({drop_a, ifa.log_addr, ifa.log_data} !== {32'd2, 32'h804, 32'd101}) begin
      fails++;
      $display("FAIL full_push_pop: got drop=%0d head=%h/%0d, want 2 804/101",
               drop_a, ifa.log_addr, ifa.log_data);
    end
    for (int k = 0; k < 8; k++) begin
      ea = (k < 7) ? 32'h804 + 32'(4 * k) : 32'h900;
      ed = (k < 7) ? 32'(101 + k) : 32'hAAAA_0000;
      tests++;
      if ({ifa.log_valid, ifa.log_addr, ifa.log_data} !== {1'b1, ea, ed}) begin
        fails++;
        $display("FAIL drain_%0d: got v=%b a=%h d=%h, want 1 %h %h",
                 k, ifa.log_valid, ifa.log_addr, ifa.log_data, ea, ed);
      end
      tick_a(0, 32'h0, 32'h0, 32'h0, 0, 1);
    end
    tests++;
    if (ifa.log_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: got log_valid=%b, want 0", ifa.log_valid);
    end
  endtask

  task automatic test_halt();
    tick_a(1, 0, 0, 0, 0, 0);
    tick_a(0, 32'h800, 32'd11, 32'h0, 1, 0);
    tick_a(0, 32'h804, 32'd22, 32'h0, 1, 0);
    tick_a(0, 32'hFFC, 32'h0, 32'h55, 0, 0);
    tests++;
    if ({halted_a, done_a, timed_out_a, cyc_a, ifa.log_addr, ifa.log_data} !==
        {1'b1, 1'b1, 1'b0, 32'd3, 32'h800, 32'd11}) begin
      fails++;
      $display("FAIL halt: got h=%b d=%b t=%b cyc=%0d head=%h/%0d, want 1 1 0 3 800/11",
               halted_a, done_a, timed_out_a, cyc_a, ifa.log_addr, ifa.log_data);
    end
    for (int i = 0; i < 3; i++) begin
      tick_a(0, 32'h800, 32'(500 + i), 32'h0, 1, 1);
      tests++;
      if ({ifa.log_valid, cyc_a, halted_a} !== {(i == 0), 32'd3, 1'b1} ||
          (i == 0 && ifa.log_data !== 32'd22)) begin
        fails++;
        $display("FAIL stopped_%0d: got v=%b d=%0d cyc=%0d h=%b, want v=%b d=22 cyc=3 h=1",
                 i, ifa.log_valid, ifa.log_data, cyc_a, halted_a, (i == 0));
      end
    end
  endtask

  task automatic test_timeout();
    tick_b(1, 0, 0, 0, 0, 0);
    for (int e = 1; e <= 16; e++) begin
      tick_b(0, (e <= 3) ? 32'h800 + 32'(4 * e) : 32'h10, 32'(e), 32'h0, (e <= 3), 0);
      if (e == 15) begin
        tests++;
        if ({cyc_b, timed_out_b} !== {32'd15, 1'b0}) begin
          fails++;
          $display("FAIL pre_timeout: got cyc=%0d t=%b, want 15 0", cyc_b, timed_out_b);
        end
      end
    end
    tests++;
    if ({timed_out_b, done_b, halted_b, cyc_b} !== {1'b1, 1'b1, 1'b0, 32'd15}) begin
      fails++;
      $display("FAIL timeout: got t=%b d=%b h=%b cyc=%0d, want 1 1 0 15",
               timed_out_b, done_b, halted_b, cyc_b);
    end
    tick_b(0, 32'h800, 32'h77, 32'h0, 1, 0);
    tests++;
    if ({cyc_b, ifb.log_valid, ifb.log_addr, ifb.log_data} !== {32'd15, 1'b1, 32'h804, 32'd1}) begin
      fails++;
      $display("FAIL timeout_hold: got cyc=%0d v=%b head=%h/%0d, want 15 1 804/1",
               cyc_b, ifb.log_valid, ifb.log_addr, ifb.log_data);
    end
    tick_b(1, 32'h800, 32'h88, 32'h0, 1, 1);
    tests++;
    if ({ifb.log_valid, halted_b, timed_out_b, done_b, overflow_b, drop_b, cyc_b} !== 69'd0) begin
      fails++;
      $display("FAIL reset_midrun: got v=%b h=%b t=%b d=%b o=%b drop=%0d cyc=%0d, want all zero",
               ifb.log_valid, halted_b, timed_out_b, done_b, overflow_b, drop_b, cyc_b);
    end
  endtask

  task automatic test_read_log();
    tick_b(1, 0, 0, 0, 0, 0);
    tick_b(0, 32'h804, 32'hFFFF_0000, 32'h1234_5678, 0, 0);
    tests++;
    if ({ifb.log_valid, ifb.log_addr, ifb.log_data, ifb.log_is_write} !==
        {1'b1, 32'h804, 32'h1234_5678, 1'b0}) begin
      fails++;
      $display("FAIL read_log: got v=%b a=%h d=%h w=%b, want 1 804 12345678 0",
               ifb.log_valid, ifb.log_addr, ifb.log_data, ifb.log_is_write);
    end
    // Halt access lands on the very edge the timeout would fire
    tick_b(1, 0, 0, 0, 0, 0);
    for (int e = 1; e <= 15; e++) tick_b(0, 32'h10, 32'h0, 32'h0, 0, 0);
    tick_b(0, 32'hFFC, 32'h0, 32'hCAFE, 0, 0);
    tests++;
    if ({halted_b, timed_out_b, done_b, ifb.log_valid, ifb.log_addr, ifb.log_data} !==
        {1'b1, 1'b0, 1'b1, 1'b1, 32'hFFC, 32'hCAFE}) begin
      fails++;
      $display("FAIL halt_vs_timeout: got h=%b t=%b d=%b v=%b head=%h/%h, want 1 0 1 1 ffc/cafe",
               halted_b, timed_out_b, done_b, ifb.log_valid, ifb.log_addr, ifb.log_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, e_a, e_d;
    logic        w, rdy, e_v, e_w;
    int          bias;
    for (int run = 0; run < 4; run++) begin
      bias = (run == 0) ? 90 : (run == 1) ? 15 : (run == 2) ? 50 : 70;
      tick_a(1, 0, 0, 0, 0, 0);
      for (int c = 0; c < 250; c++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: a = 32'h800 | (32'($urandom_range(0, 255)) << 2);
          5, 6, 7:       a = 32'($urandom_range(0, 32'h7FF));
          8:             a = $urandom;
          default:       a = ($urandom_range(0, 19) == 0) ? 32'hFFC : 32'h900;
        endcase
        wd  = $urandom;
        rd  = $urandom;
        w   = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 99) < bias);
        tick_a(0, a, wd, rd, w, rdy);
        e_v = (mq.size() != 0);
        e_a = 0; e_d = 0; e_w = 0;
        if (e_v) begin
          e_a = mq[0].addr; e_d = mq[0].data; e_w = mq[0].w;
        end
        tests++;
        if (ifa.log_valid !== e_v ||
            (e_v && {ifa.log_addr, ifa.log_data, ifa.log_is_write} !== {e_a, e_d, e_w})) begin
          fails++;
          $display("FAIL rand_head r%0d c%0d: got v=%b a=%h d=%h w=%b, want v=%b a=%h d=%h w=%b",
                   run, c, ifa.log_valid, ifa.log_addr, ifa.log_data, ifa.log_is_write,
                   e_v, e_a, e_d, e_w);
        end
        tests++;
        if ({halted_a, timed_out_a, done_a, overflow_a, drop_a, cyc_a} !==
            {m_halted, m_tmo, m_halted | m_tmo, m_ovf, m_drops, m_cycles}) begin
          fails++;
          $display("FAIL rand_status r%0d c%0d: got h=%b t=%b d=%b o=%b drop=%0d cyc=%0d, want %b %b %b %b %0d %0d",
                   run, c, halted_a, timed_out_a, done_a, overflow_a, drop_a, cyc_a,
                   m_halted, m_tmo, m_halted | m_tmo, m_ovf, m_drops, m_cycles);
        end
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.address = 0; ifa.data_wr = 0; ifa.data_rd = 0; ifa.we = 0; ifa.log_ready = 0;
    ifb.address = 0; ifb.data_wr = 0; ifb.data_rd = 0; ifb.we = 0; ifb.log_ready = 0;
    test_reset();
    test_single_write();
    test_overflow();
    test_full_push_pop();
    test_halt();
    test_timeout();
    test_read_log();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_monitor.md
BUS_MONITOR -- requirements
Module: bus_monitor

Interface
REQ-001 Parameter ADDR_W, default 32: width of the core address bus.
REQ-002 Parameter DATA_W, default 32: width of the core data buses.
REQ-003 Parameter HALT_ADDR, default 'hFFC: an access to this address ends the run.
REQ-004 Parameter MMIO_BIT, default 11: an access with address[MMIO_BIT]=1 is an MMIO-window access.
REQ-005 Parameter LOG_READS, default 0: when 1, MMIO reads are logged in addition to MMIO writes.
REQ-006 Parameter FIFO_DEPTH, default 8, power of two >= 2: depth of the log FIFO.
REQ-007 Parameter TIMEOUT, default 4000: run cycle limit; CNT_W = 32 bits for all counters.
REQ-008 clk  input  1  single clock; all state updates on the rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 address  input  ADDR_W  core address bus.
REQ-011 data_wr  input  DATA_W  core write data (core data_out).
REQ-012 data_rd  input  DATA_W  memory read data (memory data_out).
REQ-013 we  input  1  core write enable.
REQ-014 log_valid  output  1  FIFO head holds a log entry.
REQ-015 log_ready  input  1  consumer accepts the head entry.
REQ-016 log_addr  output  ADDR_W  address of the head entry.
REQ-017 log_data  output  DATA_W  data of the head entry.
REQ-018 log_is_write  output  1  head entry was a write (1) or read (0).
REQ-019 halted  output  1  sticky: HALT_ADDR was accessed.
REQ-020 timed_out  output  1  sticky: TIMEOUT cycles elapsed without halt.
REQ-021 done  output  1  halted OR timed_out.
REQ-022 overflow  output  1  sticky: at least one event was dropped.
REQ-023 drop_count  output  CNT_W  number of dropped events, saturating.
REQ-024 cycle_count  output  CNT_W  cycles since reset release, frozen once done.

Function
REQ-025 Inputs are sampled on each rising clk edge with reset=0; state is RUN while done=0, STOPPED once done=1; STOPPED is left only by reset.
REQ-026 An event is qualified in RUN when address[MMIO_BIT]=1 and (we=1 or LOG_READS=1).
REQ-027 A qualified event pushes {address, we ? data_wr : data_rd, we} into the FIFO.
REQ-028 Push-to-log_valid latency: one cycle; an event sampled at edge N on an empty FIFO gives log_valid=1 after edge N.
REQ-029 A pop occurs at an edge where log_valid=1 and log_ready=1; log_* outputs hold stable while log_valid=1 and log_ready=0.
REQ-030 FIFO ordering is strict first-in first-out; log_addr/log_data/log_is_write are don't-care when log_valid=0.
REQ-031 Push on a full FIFO with no same-edge pop: entry dropped, overflow set, drop_count increments, saturating at all-ones.
REQ-032 Push on a full FIFO with a same-edge pop: pop and push both succeed, and nothing is dropped.
REQ-033 Push and pop on the same edge with FIFO neither empty nor full: occupancy is unchanged.
REQ-034 Pointers wrap modulo FIFO_DEPTH with no gap or duplicate entry.
REQ-035 In RUN, address == HALT_ADDR at an edge sets halted after that edge; if that access also qualifies, it is logged.
REQ-036 cycle_count increments at each edge in RUN; when it reaches TIMEOUT-1 with no halt, timed_out sets at the next edge.
REQ-037 Halt and timeout on the same edge: halted=1, and timed_out stays 0.
REQ-038 In STOPPED: no pushes, counters frozen, FIFO still drains via log_ready.

Reset
REQ-039 Reset=1 at an edge clears FIFO pointers and occupancy; log_valid=0, halted=0, timed_out=0, done=0, overflow=0, drop_count=0, cycle_count=0.
REQ-040 Reset mid-run discards all unread entries; bus inputs sampled during reset are ignored.
REQ-041 The first event can be qualified at the first edge with reset=0.

Verification
REQ-042 Write 0xDEADBEEF to 0x800, log_ready=1 -> log_valid=1 for one cycle next cycle with log_addr=0x800, log_data=0xDEADBEEF, log_is_write=1.
REQ-043 log_ready=0, 10 consecutive MMIO writes, FIFO_DEPTH=8 -> 8 entries retained in order, overflow=1, drop_count=2.
REQ-044 FIFO full, log_ready=1 with a write on the same edge -> drop_count unchanged, occupancy stays 8, new entry last.
REQ-045 Access address 0xFFC with we=0, LOG_READS=0 -> halted=1, done=1, next writes to 0x800 not logged, cycle_count frozen.
REQ-046 TIMEOUT=16, no halt access -> timed_out=1 after edge 16, cycle_count=15 held; assert reset with 3 entries queued -> all outputs zero next cycle.
REQ-047 LOG_READS=1, read 0x804 with data_rd=0x12345678 -> entry with log_is_write=0, log_data=0x12345678.
